// File: rtl/ysyx_24110006_axi_arbiter_pkg.sv
// rtl/ysyx_24110006_axi_arbiter_pkg.sv - shared types and AXI constants for the IFU/LSU AXI arbiter
package ysyx_24110006_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4
    } arb_state_e;

    // Master index: bit 0 of the grant vector is the IFU, bit 1 the LSU
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic [1:0] owner_onehot(owner_e o);
        return (o == OWN_LSU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_24110006_axi_arbiter_if.sv
// rtl/ysyx_24110006_axi_arbiter_if.sv - full AXI4 channel bundle with master/slave views
interface ysyx_24110006_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [3:0]          arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;
    logic [1:0]          rresp;
    logic                rlast;
    logic [3:0]          rid;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [3:0]          awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [3:0]          bid;

    modport mst (
        output araddr, arvalid, arid, arlen, arsize, arburst, input arready,
        input  rdata, rvalid, rresp, rlast, rid, output rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst, input awready,
        output wdata, wstrb, wvalid, wlast, input wready,
        input  bvalid, bresp, bid, output bready
    );

    modport slv (
        input  araddr, arvalid, arid, arlen, arsize, arburst, output arready,
        output rdata, rvalid, rresp, rlast, rid, input rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst, output awready,
        input  wdata, wstrb, wvalid, wlast, output wready,
        output bvalid, bresp, bid, input bready
    );

endinterface

// File: rtl/ysyx_24110006_rr_arbiter2.sv
// rtl/ysyx_24110006_rr_arbiter2.sv - two-way combinational arbiter, round-robin or LSU-priority on a tie
module ysyx_24110006_rr_arbiter2
    import ysyx_24110006_axi_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req_i,
    input  owner_e     last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (RR_EN && (last_grant_i == OWN_LSU)) grant_o = 2'b01;
                else                                    grant_o = 2'b10;
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_axi_arbiter.sv
// rtl/ysyx_24110006_axi_arbiter.sv - serialises IFU and LSU AXI4 traffic onto one slave port
module ysyx_24110006_axi_arbiter
    import ysyx_24110006_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                            i_clock,
    input  logic                            i_reset_n,
    ysyx_24110006_axi_arbiter_if.slv        m0_io,
    ysyx_24110006_axi_arbiter_if.slv        m1_io,
    ysyx_24110006_axi_arbiter_if.mst        s_io,
    output logic [1:0]                      o_grant,
    output logic                            o_busy
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    owner_e     last_grant_q, last_grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic       in_raddr, in_rdata, in_waddr, in_wresp, own_lsu;
    logic [ADDR_W-1:0] own_araddr;
    logic [DATA_W-1:0] rdata_fwd;

    assign req = {m1_io.awvalid | m1_io.arvalid, m0_io.arvalid};

    ysyx_24110006_rr_arbiter2 #(.RR_EN(RR_EN)) u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign in_raddr = (state_q == ST_RADDR);
    assign in_rdata = (state_q == ST_RDATA);
    assign in_waddr = (state_q == ST_WADDR);
    assign in_wresp = (state_q == ST_WRESP);
    assign own_lsu  = (owner_q == OWN_LSU);

    assign ar_hs = s_io.arvalid & s_io.arready;
    assign r_hs  = s_io.rvalid  & s_io.rready;
    assign aw_hs = s_io.awvalid & s_io.awready;
    assign w_hs  = s_io.wvalid  & s_io.wready;
    assign b_hs  = s_io.bvalid  & s_io.bready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d      = grant[1] ? OWN_LSU : OWN_IFU;
                    last_grant_d = owner_d;
                    // A pending LSU write takes precedence over its own read
                    state_d      = (grant[1] && m1_io.awvalid) ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: if (ar_hs) state_d = ST_RDATA;
            ST_RDATA: if (r_hs && s_io.rlast) state_d = ST_IDLE;
            ST_WADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRESP;
                end
            end
            ST_WRESP: if (b_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign own_araddr = own_lsu ? m1_io.araddr : m0_io.araddr;
    assign rdata_fwd  = s_io.rdata;

    // Payload is muxed freely; only valids and readies are gated by state
    always_comb begin
        s_io.araddr  = own_araddr;
        s_io.arid    = own_lsu ? m1_io.arid    : m0_io.arid;
        s_io.arlen   = own_lsu ? m1_io.arlen   : m0_io.arlen;
        s_io.arsize  = own_lsu ? m1_io.arsize  : m0_io.arsize;
        s_io.arburst = own_lsu ? m1_io.arburst : m0_io.arburst;
        s_io.arvalid = in_raddr & (own_lsu ? m1_io.arvalid : m0_io.arvalid);
        s_io.rready  = in_rdata & (own_lsu ? m1_io.rready  : m0_io.rready);
        s_io.awaddr  = m1_io.awaddr;
        s_io.awid    = m1_io.awid;
        s_io.awlen   = m1_io.awlen;
        s_io.awsize  = m1_io.awsize;
        s_io.awburst = m1_io.awburst;
        s_io.awvalid = in_waddr & ~aw_done_q & m1_io.awvalid;
        s_io.wdata   = m1_io.wdata;
        s_io.wstrb   = m1_io.wstrb;
        s_io.wlast   = m1_io.wlast;
        s_io.wvalid  = in_waddr & ~w_done_q & m1_io.wvalid;
        s_io.bready  = in_wresp & m1_io.bready;
    end

    always_comb begin
        m0_io.arready = in_raddr & ~own_lsu & s_io.arready;
        m0_io.rdata   = rdata_fwd;
        m0_io.rresp   = s_io.rresp;
        m0_io.rlast   = s_io.rlast;
        m0_io.rid     = s_io.rid;
        m0_io.rvalid  = in_rdata & ~own_lsu & s_io.rvalid;
        m0_io.awready = 1'b0;
        m0_io.wready  = 1'b0;
        m0_io.bvalid  = 1'b0;
        m0_io.bresp   = AXI_RESP_OKAY;
        m0_io.bid     = 4'd0;

        m1_io.arready = in_raddr & own_lsu & s_io.arready;
        m1_io.rdata   = rdata_fwd;
        m1_io.rresp   = s_io.rresp;
        m1_io.rlast   = s_io.rlast;
        m1_io.rid     = s_io.rid;
        m1_io.rvalid  = in_rdata & own_lsu & s_io.rvalid;
        m1_io.awready = in_waddr & ~aw_done_q & s_io.awready;
        m1_io.wready  = in_waddr & ~w_done_q & s_io.wready;
        m1_io.bvalid  = in_wresp & s_io.bvalid;
        m1_io.bresp   = s_io.bresp;
        m1_io.bid     = s_io.bid;
    end

    // The IFU port is read-only; its write-side inputs are intentionally ignored
    logic unused_m0_write;
    assign unused_m0_write = ^{m0_io.awaddr, m0_io.awvalid, m0_io.awid, m0_io.awlen,
                               m0_io.awsize, m0_io.awburst, m0_io.wdata, m0_io.wstrb,
                               m0_io.wvalid, m0_io.wlast, m0_io.bready};

    assign o_busy  = (state_q != ST_IDLE);
    assign o_grant = o_busy ? owner_onehot(owner_q) : 2'b00;

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// tb/tb_ysyx_24110006_axi_arbiter.sv - directed self-checking bench for the IFU/LSU AXI arbiter
module tb_ysyx_24110006_axi_arbiter;
    import ysyx_24110006_axi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] grant_a, grant_b;
    logic busy_a, busy_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24110006_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
    ysyx_24110006_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
    ysyx_24110006_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s ();
    ysyx_24110006_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0b ();
    ysyx_24110006_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1b ();
    ysyx_24110006_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sb ();

    ysyx_24110006_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n), .m0_io(m0), .m1_io(m1), .s_io(s),
        .o_grant(grant_a), .o_busy(busy_a));

    ysyx_24110006_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_dut_fix (
        .i_clock(clk), .i_reset_n(rst_n), .m0_io(m0b), .m1_io(m1b), .s_io(sb),
        .o_grant(grant_b), .o_busy(busy_b));

    typedef struct {
        logic       m0;
        logic       ar1;
        logic       aw1;
        logic [1:0] g1;
        logic       wr1;
        logic [1:0] g2;
        logic       wr2;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Grant already registered: check it, then run the owner's transaction to completion
    task automatic serve_one(input logic [1:0] g, input logic wr, input logic [31:0] rd);
        settle();
        chk("serve_grant", grant_a, g);
        chk("serve_awvalid", s.awvalid, wr);
        chk("serve_arvalid", s.arvalid, !wr);
        if (wr) begin
            chk("serve_awaddr", s.awaddr, 32'h8000_2000);
            s.awready = 1'b1; s.wready = 1'b1;
            step();
            s.awready = 1'b0; s.wready = 1'b0; m1.awvalid = 1'b0; m1.wvalid = 1'b0;
            s.bvalid = 1'b1; s.bresp = AXI_RESP_OKAY; m1.bready = 1'b1;
            settle();
            chk("serve_bvalid", m1.bvalid, 1'b1);
            step();
            s.bvalid = 1'b0; m1.bready = 1'b0;
        end else begin
            chk("serve_araddr", s.araddr, (g == 2'b01) ? 32'h8000_0000 : 32'h8000_1000);
            s.arready = 1'b1;
            settle();
            chk("serve_own_arready", (g == 2'b01) ? m0.arready : m1.arready, 1'b1);
            chk("serve_oth_arready", (g == 2'b01) ? m1.arready : m0.arready, 1'b0);
            step();
            s.arready = 1'b0;
            if (g == 2'b01) m0.arvalid = 1'b0; else m1.arvalid = 1'b0;
            s.rvalid = 1'b1; s.rlast = 1'b1; s.rdata = rd; m0.rready = 1'b1; m1.rready = 1'b1;
            settle();
            chk("serve_own_rvalid", (g == 2'b01) ? m0.rvalid : m1.rvalid, 1'b1);
            chk("serve_oth_rvalid", (g == 2'b01) ? m1.rvalid : m0.rvalid, 1'b0);
            chk("serve_rdata", (g == 2'b01) ? m0.rdata : m1.rdata, rd);
            step();
            s.rvalid = 1'b0; s.rlast = 1'b0; m0.rready = 1'b0; m1.rready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int beat, stall, ntx;
        logic [1:0] prev;
        logic exp_rdy;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b10, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b10, 1'b0};

        {m0.araddr, m0.arvalid, m0.arid, m0.arlen, m0.arsize, m0.arburst, m0.rready} = '0;
        {m0.awaddr, m0.awvalid, m0.awid, m0.awlen, m0.awsize, m0.awburst} = '0;
        {m0.wdata, m0.wstrb, m0.wvalid, m0.wlast, m0.bready} = '0;
        {m1.araddr, m1.arvalid, m1.arid, m1.arlen, m1.arsize, m1.arburst, m1.rready} = '0;
        {m1.awaddr, m1.awvalid, m1.awid, m1.awlen, m1.awsize, m1.awburst} = '0;
        {m1.wdata, m1.wstrb, m1.wvalid, m1.wlast, m1.bready} = '0;
        {s.arready, s.rdata, s.rvalid, s.rresp, s.rlast, s.rid} = '0;
        {s.awready, s.wready, s.bvalid, s.bresp, s.bid} = '0;
        {m0b.araddr, m0b.arvalid, m0b.arid, m0b.arlen, m0b.arsize, m0b.arburst, m0b.rready} = '0;
        {m0b.awaddr, m0b.awvalid, m0b.awid, m0b.awlen, m0b.awsize, m0b.awburst} = '0;
        {m0b.wdata, m0b.wstrb, m0b.wvalid, m0b.wlast, m0b.bready} = '0;
        {m1b.araddr, m1b.arvalid, m1b.arid, m1b.arlen, m1b.arsize, m1b.arburst, m1b.rready} = '0;
        {m1b.awaddr, m1b.awvalid, m1b.awid, m1b.awlen, m1b.awsize, m1b.awburst} = '0;
        {m1b.wdata, m1b.wstrb, m1b.wvalid, m1b.wlast, m1b.bready} = '0;
        {sb.arready, sb.rdata, sb.rvalid, sb.rresp, sb.rlast, sb.rid} = '0;
        {sb.awready, sb.wready, sb.bvalid, sb.bresp, sb.bid} = '0;

        // Reset: slave-side stimuli must not leak through while held in reset
        s.arready = 1'b1; s.rvalid = 1'b1; s.bvalid = 1'b1; m0.rready = 1'b1; m1.bready = 1'b1;
        #3;
        chk("rst_grant", grant_a, 2'b00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_s_rready", s.rready, 1'b0);
        chk("rst_s_bready", s.bready, 1'b0);
        chk("rst_m0_rvalid", m0.rvalid, 1'b0);
        chk("rst_m1_bvalid", m1.bvalid, 1'b0);
        chk("rst_m0_arready", m0.arready, 1'b0);
        chk("rst_s_awvalid", s.awvalid, 1'b0);
        s.arready = 1'b0; s.rvalid = 1'b0; s.bvalid = 1'b0; m0.rready = 1'b0; m1.bready = 1'b0;
        step();
        rst_n = 1'b1;

        // IFU read, arready one cycle late
        m0.araddr = 32'h8000_0000; m0.arburst = AXI_BURST_FIXED; m0.arvalid = 1'b1;
        m1.araddr = 32'h8000_1000; m1.awaddr = 32'h8000_2000; m1.wstrb = 4'hF; m1.wlast = 1'b1;
        settle();
        chk("t1_idle_grant", grant_a, 2'b00);
        chk("t1_idle_arvalid", s.arvalid, 1'b0);
        step(); settle();
        chk("t1_grant", grant_a, 2'b01);
        chk("t1_arvalid", s.arvalid, 1'b1);
        chk("t1_arburst", s.arburst, AXI_BURST_FIXED);
        chk("t1_arready_wait", m0.arready, 1'b0);
        step(); settle();
        chk("t1_arvalid_held", s.arvalid, 1'b1);
        s.arready = 1'b1; settle();
        chk("t1_arready", m0.arready, 1'b1);
        step();
        s.arready = 1'b0; m0.arvalid = 1'b0;
        s.rvalid = 1'b1; s.rdata = 32'hDEAD_BEEF; s.rlast = 1'b1; m0.rready = 1'b1;
        settle();
        chk("t1_m0_rvalid", m0.rvalid, 1'b1);
        chk("t1_m0_rdata", m0.rdata, 32'hDEAD_BEEF);
        chk("t1_m1_rvalid", m1.rvalid, 1'b0);
        chk("t1_s_rready", s.rready, 1'b1);
        step();
        s.rvalid = 1'b0; s.rlast = 1'b0; m0.rready = 1'b0;
        settle();
        chk("t1_back_idle", grant_a, 2'b00);
        chk("t1_not_busy", busy_a, 1'b0);

        // Arbitration table: last_grant carries over from one vector to the next
        for (int i = 0; i < 7; i++) begin
            m0.arvalid = vecs[i].m0; m1.arvalid = vecs[i].ar1;
            m1.awvalid = vecs[i].aw1; m1.wvalid = vecs[i].aw1;
            settle();
            chk("vec_idle", grant_a, 2'b00);
            step();
            serve_one(vecs[i].g1, vecs[i].wr1, 32'h1111_0000 + i);
            if (vecs[i].g2 != 2'b00) begin
                settle();
                chk("vec_gap_idle", grant_a, 2'b00);
                step();
                serve_one(vecs[i].g2, vecs[i].wr2, 32'h2222_0000 + i);
            end
        end

        // LSU write with late wready; IFU request waits until after B
        m1.wdata = 32'h0BAD_F00D; m1.awvalid = 1'b1; m1.wvalid = 1'b1;
        step(); settle();
        chk("t3_grant", grant_a, 2'b10);
        s.awready = 1'b1; m0.arvalid = 1'b1; s.arready = 1'b1;
        settle();
        chk("t3_awvalid_first", s.awvalid, 1'b1);
        chk("t4_arready_waddr", m0.arready, 1'b0);
        step();
        m1.awvalid = 1'b0;
        settle();
        chk("t3_awvalid_dropped", s.awvalid, 1'b0);
        chk("t3_awready_forced", m1.awready, 1'b0);
        chk("t3_wvalid_held", s.wvalid, 1'b1);
        chk("t3_wdata", s.wdata, 32'h0BAD_F00D);
        step(); step(); settle();
        chk("t3_still_waddr", s.wvalid, 1'b1);
        s.wready = 1'b1; settle();
        chk("t3_wready_fwd", m1.wready, 1'b1);
        step();
        s.wready = 1'b0; s.awready = 1'b0; m1.wvalid = 1'b0;
        settle();
        chk("t3_wresp_wvalid", s.wvalid, 1'b0);
        chk("t4_arready_wresp", m0.arready, 1'b0);
        s.bvalid = 1'b1; s.bresp = AXI_RESP_SLVERR; s.bid = 4'h5; m1.bready = 1'b1;
        settle();
        chk("t3_bvalid", m1.bvalid, 1'b1);
        chk("t3_bresp", m1.bresp, 2'b10);
        chk("t3_bid", m1.bid, 4'h5);
        step();
        s.bvalid = 1'b0; m1.bready = 1'b0; s.arready = 1'b0;
        settle();
        chk("t4_idle_after_b", grant_a, 2'b00);
        chk("t4_arready_idle", m0.arready, 1'b0);
        step();
        serve_one(2'b01, 1'b0, 32'hCAFE_0004);

        // IFU 4-beat burst with a 2-cycle rready stall on beat 1
        m0.arlen = 8'd3; m0.arburst = AXI_BURST_INCR; m0.arvalid = 1'b1;
        step(); settle();
        chk("t5_arlen", s.arlen, 8'd3);
        s.arready = 1'b1;
        step();
        s.arready = 1'b0; m0.arvalid = 1'b0; s.rvalid = 1'b1;
        beat = 0; stall = 0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            s.rdata = 32'hA000_0000 + beat;
            s.rlast = (beat == 3);
            s.rresp = (beat == 3) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            exp_rdy = !(beat == 1 && stall < 2);
            m0.rready = exp_rdy;
            settle();
            chk("t5_s_rready", s.rready, exp_rdy);
            chk("t5_grant", grant_a, 2'b01);
            chk("t5_rdata", m0.rdata, 32'hA000_0000 + beat);
            if (beat == 3) chk("t5_rresp", m0.rresp, AXI_RESP_DECERR);
            if (exp_rdy) beat++; else stall++;
            step();
        end
        s.rvalid = 1'b0; s.rlast = 1'b0; s.rresp = AXI_RESP_OKAY; m0.rready = 1'b0; m0.arlen = 8'd0;
        settle();
        chk("t5_beats", beat, 4);
        chk("t5_stalls", stall, 2);
        chk("t5_idle", grant_a, 2'b00);

        // Spurious slave responses in IDLE are neither consumed nor forwarded
        s.rvalid = 1'b1; s.bvalid = 1'b1; m0.rready = 1'b1; m1.bready = 1'b1;
        settle();
        chk("idle_s_rready", s.rready, 1'b0);
        chk("idle_s_bready", s.bready, 1'b0);
        chk("idle_m0_rvalid", m0.rvalid, 1'b0);
        chk("idle_m1_bvalid", m1.bvalid, 1'b0);
        s.rvalid = 1'b0; s.bvalid = 1'b0; m0.rready = 1'b0; m1.bready = 1'b0;

        // Asynchronous reset while in RDATA
        m0.arvalid = 1'b1;
        step();
        s.arready = 1'b1;
        step();
        s.arready = 1'b0; m0.arvalid = 1'b0; s.rvalid = 1'b1; m0.rready = 1'b1;
        settle();
        chk("t6_in_rdata", m0.rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_grant", grant_a, 2'b00);
        chk("t6_busy", busy_a, 1'b0);
        chk("t6_s_rready", s.rready, 1'b0);
        chk("t6_m0_rvalid", m0.rvalid, 1'b0);
        s.rvalid = 1'b0; m0.rready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        m0.arvalid = 1'b1;
        settle();
        chk("t6_idle_after", grant_a, 2'b00);
        step();
        serve_one(2'b01, 1'b0, 32'h6666_0006);

        // Fixed-priority instance: with both always requesting, LSU wins every tie
        m0b.araddr = 32'h8000_0000; m1b.araddr = 32'h8000_1000;
        m0b.arvalid = 1'b1; m1b.arvalid = 1'b1; m0b.rready = 1'b1; m1b.rready = 1'b1;
        sb.arready = 1'b1; sb.rvalid = 1'b1; sb.rlast = 1'b1;
        prev = 2'b00; ntx = 0;
        for (int c = 0; c < 12; c++) begin
            step(); settle();
            chk("fix_no_ifu_grant", grant_b[0], 1'b0);
            chk("fix_m0_arready", m0b.arready, 1'b0);
            if (prev == 2'b00 && grant_b == 2'b10) ntx++;
            prev = grant_b;
        end
        chk("fix_lsu_txns", ntx, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
